// File: rtl/pipe_pkg.sv
// Shared definitions for the instruction fetch path.
package pipe_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    F_REQ  = 2'd0,
    F_WAIT = 2'd1,
    F_DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Two-entry {pc, instr} FIFO between instruction memory and decode.
// Used only when fetch_unit is built with FETCH_BUF_EN.
module fetch_buf
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign do_push = push && (count != 2'd2);
  assign do_pop  = pop && (count != 2'd0);
  assign head    = mem[rd_ptr];

  // Pointer, occupancy and storage update; flush drops all entries at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        mem[i] <= '{pc: RESET_PC, instr: NOP_INSTR};
      end
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding request, redirect flush, stall hold.
// Define FETCH_BUF_EN to place a 2-entry FIFO (fetch_buf) in front of decode;
// otherwise a single output register holds the presented instruction.
//
// state  | meaning
// F_REQ  | request may be issued (when capture room exists)
// F_WAIT | request accepted, waiting for imem_rvalid
// F_DROP | request was flushed by redirect, discard its response
module fetch_unit #(
  parameter logic [31:0] RESET_PC = pipe_pkg::DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall_in,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        instr_valid
);
  import pipe_pkg::*;

  fetch_state_t state;
  logic [31:0]  pc;
  logic         room;
  logic         present;
  logic         consume;
  logic         hs;
  logic         capture;

  // Reset gates the request so nothing is offered to memory while rst is high.
  assign imem_addr = pc;
  assign imem_req  = !rst && (state == F_REQ) && room;
  assign hs        = imem_req && imem_ready;
  assign capture   = (state == F_WAIT) && imem_rvalid && !redirect_en;
  assign consume   = present && !stall_in;

`ifdef FETCH_BUF_EN
  fetch_entry_t head;
  fetch_entry_t push_data;
  logic [1:0]   count;
  logic         outstanding;

  assign outstanding = (state == F_WAIT);
  assign room        = (({1'b0, count} + {2'b00, outstanding}) < 3'd2);
  assign present     = (count != 2'd0);
  assign push_data   = '{pc: pc, instr: imem_rdata};

  fetch_buf #(.RESET_PC(RESET_PC)) u_fetch_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_en),
    .push      (capture),
    .push_data (push_data),
    .pop       (consume),
    .head      (head),
    .count     (count)
  );

  assign instr_valid = present;
  assign instr_out   = present ? head.instr : NOP_INSTR;
  assign pc_out      = head.pc;
`else
  logic [31:0] instr_q;
  logic [31:0] pc_q;
  logic        valid_q;

  assign present     = valid_q;
  assign room        = !valid_q || consume;
  assign instr_valid = valid_q;
  assign instr_out   = instr_q;
  assign pc_out      = pc_q;

  // Output register: flush on redirect, load on capture, clear on consume.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q <= NOP_INSTR;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
    end else if (redirect_en) begin
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (capture) begin
      instr_q <= imem_rdata;
      pc_q    <= pc;
      valid_q <= 1'b1;
    end else if (consume) begin
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end
  end
`endif

  // Fetch FSM and PC. A redirect whose stale response is still in flight
  // (accepted now, or waiting without rvalid this cycle) must go to F_DROP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= F_REQ;
      pc    <= RESET_PC;
    end else if (redirect_en) begin
      pc <= redirect_pc;
      if (hs || ((state == F_WAIT) && !imem_rvalid) ||
          ((state == F_DROP) && !imem_rvalid)) begin
        state <= F_DROP;
      end else begin
        state <= F_REQ;
      end
    end else begin
      case (state)
        F_REQ: begin
          if (hs) state <= F_WAIT;
        end
        F_WAIT: begin
          if (imem_rvalid) begin
            state <= F_REQ;
            pc    <= pc + 32'd4;
          end
        end
        F_DROP: begin
          if (imem_rvalid) state <= F_REQ;
        end
        default: state <= F_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios push expected {pc, instr}
// pairs; a monitor pops and compares on every consumed instruction.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall_in;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        instr_valid;

  int checks = 0;
  int errors = 0;
  int lat = 1;
  logic [63:0] sb[$];
  logic [31:0] req_log[$];

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .stall_in    (stall_in),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .instr_out   (instr_out),
    .pc_out      (pc_out),
    .instr_valid (instr_valid)
  );

  always #5 clk = ~clk;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem_word = 32'h0050_0093;
      32'h0000_0004: mem_word = 32'h00a0_0113;
      32'h0000_0008: mem_word = 32'h00f0_0193;
      32'h0000_000c: mem_word = 32'h0140_0213;
      32'h0000_0100: mem_word = 32'h0200_0293;
      32'h0000_0104: mem_word = 32'h02a0_0313;
      32'h0000_0200: mem_word = 32'h0300_0393;
      default:       mem_word = 32'hbad0_0000 ^ a;
    endcase
  endfunction

  // Memory responder: handshake seen before an edge, data returned lat cycles later.
  initial begin
    logic [31:0] a;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst && imem_req && imem_ready) begin
        a = imem_addr;
        req_log.push_back(a);
        repeat (lat) @(posedge clk);
        #1;
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(a);
        @(posedge clk);
        #1;
        imem_rvalid = 1'b0;
      end
    end
  end

  // Monitor: every instruction consumed by decode must match the scoreboard head.
  always @(negedge clk) begin
    if (!rst && instr_valid && !stall_in && !redirect_en) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_instr actual pc=%h instr=%h required=none", pc_out, instr_out);
      end else begin
        logic [63:0] e;
        e = sb.pop_front();
        check32("mon_pc", pc_out, e[63:32]);
        check32("mon_instr", instr_out, e[31:0]);
      end
    end
  end

  task automatic wait_log(input int n);
    int i;
    for (i = 0; i < 40; i++) begin
      @(posedge clk);
      if (req_log.size() >= n) break;
    end
    checks++;
    if (req_log.size() < n) begin
      errors++;
      $display("FAIL wait_log_timeout actual=%0d required=%0d", req_log.size(), n);
    end
    #1;
  endtask

  task automatic wait_valid();
    int i;
    for (i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (instr_valid) break;
    end
    check32("wait_valid", {31'b0, instr_valid}, 32'd1);
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
    check32("drain_left", sb.size(), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic reset_checks(input string tag);
    check32({tag, "_req"}, {31'b0, imem_req}, 32'd0);
    check32({tag, "_valid"}, {31'b0, instr_valid}, 32'd0);
    check32({tag, "_instr"}, instr_out, NOP);
    check32({tag, "_pc"}, pc_out, 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    imem_ready = 1'b0;
    stall_in = 1'b0;
    redirect_en = 1'b0;
    redirect_pc = 32'h0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    reset_checks("rst0");
    check32("rst0_addr", imem_addr, 32'h0);

    // First fetch and three sequential fetches
    sb.push_back({32'h0, 32'h0050_0093});
    sb.push_back({32'h4, 32'h00a0_0113});
    sb.push_back({32'h8, 32'h00f0_0193});
    rst = 1'b0;
    imem_ready = 1'b1;
    #1;
    check32("first_req", {31'b0, imem_req}, 32'd1);
    check32("first_addr", imem_addr, 32'h0);
    wait_log(3);
    imem_ready = 1'b0;
    drain();
    check32("seq_log_n", req_log.size(), 32'd3);
    if (req_log.size() >= 3) begin
      check32("seq_log0", req_log[0], 32'h0);
      check32("seq_log1", req_log[1], 32'h4);
      check32("seq_log2", req_log[2], 32'h8);
    end

    // Stall with instruction at PC 4 presented
    redirect_en = 1'b1;
    redirect_pc = 32'h4;
    @(posedge clk);
    #1;
    redirect_en = 1'b0;
    req_log.delete();
    stall_in = 1'b1;
    imem_ready = 1'b1;
    wait_valid();
    for (int c = 0; c < 3; c++) begin
      check32("stall_pc", pc_out, 32'h4);
      check32("stall_instr", instr_out, 32'h00a0_0113);
      @(posedge clk);
      #1;
    end
`ifdef FETCH_BUF_EN
    check32("stall_log_n", req_log.size(), 32'd2);
    if (req_log.size() >= 2) check32("stall_log1", req_log[1], 32'h8);
`else
    check32("stall_log_n", req_log.size(), 32'd1);
`endif
    if (req_log.size() >= 1) check32("stall_log0", req_log[0], 32'h4);
    imem_ready = 1'b0;
    sb.push_back({32'h4, 32'h00a0_0113});
`ifdef FETCH_BUF_EN
    sb.push_back({32'h8, 32'h00f0_0193});
`endif
    stall_in = 1'b0;
    drain();

    // Redirect while waiting: stale response dropped
    lat = 3;
    req_log.delete();
    imem_ready = 1'b1;
    wait_log(1);
    imem_ready = 1'b0;
    redirect_en = 1'b1;
    redirect_pc = 32'h100;
    lat = 1;
    @(posedge clk);
    #1;
    redirect_en = 1'b0;
    check32("redir_valid", {31'b0, instr_valid}, 32'd0);
    sb.push_back({32'h100, 32'h0200_0293});
    imem_ready = 1'b1;
    wait_log(2);
    imem_ready = 1'b0;
    if (req_log.size() >= 2) check32("redir_addr", req_log[1], 32'h100);
    drain();

    // Redirect and stall together: flush wins
    req_log.delete();
    stall_in = 1'b1;
    imem_ready = 1'b1;
    wait_valid();
    imem_ready = 1'b0;
    check32("flush_pre_pc", pc_out, 32'h104);
    check32("flush_pre_instr", instr_out, 32'h02a0_0313);
    redirect_en = 1'b1;
    redirect_pc = 32'h200;
    @(posedge clk);
    #1;
    redirect_en = 1'b0;
    check32("flush_valid", {31'b0, instr_valid}, 32'd0);
    check32("flush_instr", instr_out, NOP);
    stall_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check32("flush_idle_valid", {31'b0, instr_valid}, 32'd0);

    // Reset pulse during an outstanding request
    lat = 3;
    req_log.delete();
    imem_ready = 1'b1;
    wait_log(1);
    imem_ready = 1'b0;
    if (req_log.size() >= 1) check32("rst_pre_addr", req_log[0], 32'h200);
    rst = 1'b1;
    #1;
    reset_checks("rst1");
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check32("rst1_req", {31'b0, imem_req}, 32'd1);
    check32("rst1_addr", imem_addr, 32'h0);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      check32("rst1_stale_valid", {31'b0, instr_valid}, 32'd0);
    end
    lat = 1;
    sb.push_back({32'h0, 32'h0050_0093});
    imem_ready = 1'b1;
    wait_log(2);
    imem_ready = 1'b0;
    if (req_log.size() >= 2) check32("rst1_first_addr", req_log[1], 32'h0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL use parameter RESET_PC, default 32'h0000_0000, as the byte address of the first fetch after reset.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 imem_req  output  1  fetch request to instruction memory.
REQ-005 imem_addr  output  32  byte address of the request; always equal to the internal PC.
REQ-006 imem_ready  input  1  memory accepts the request in this cycle.
REQ-007 imem_rvalid  input  1  imem_rdata is valid; cannot be back-pressured.
REQ-008 imem_rdata  input  32  returned instruction word.
REQ-009 stall_in  input  1  decode stage holds the current instruction (controller stall).
REQ-010 redirect_en  input  1  branch/jump taken; flush and refetch.
REQ-011 redirect_pc  input  32  target byte address; valid when redirect_en=1.
REQ-012 instr_out  output  32  instruction presented to the decode stage.
REQ-013 pc_out  output  32  byte address of instr_out.
REQ-014 instr_valid  output  1  instr_out/pc_out hold a real fetched instruction.

Function
REQ-015 A request SHALL complete when imem_req=1 and imem_ready=1 in the same cycle; at most one request SHALL be outstanding.
REQ-016 The FSM SHALL have states F_REQ, F_WAIT, F_DROP: F_REQ -> F_WAIT on handshake; F_WAIT -> F_REQ on imem_rvalid; F_DROP -> F_REQ on imem_rvalid.
REQ-017 imem_req SHALL be 1 only in F_REQ, and only when capture room exists (see REQ-024/REQ-029).
REQ-018 On imem_rvalid in F_WAIT, the word SHALL be captured with its PC, and the PC SHALL advance by 4 (wrap modulo 2^32).
REQ-019 An instruction SHALL be consumed when instr_valid=1 and stall_in=0.
REQ-020 While instr_valid=1 and stall_in=1, instr_out and pc_out SHALL hold unchanged.
REQ-021 When no instruction is presented, instr_valid SHALL be 0 and instr_out SHALL be NOP_INSTR (32'h0000_0013).
REQ-022 redirect_en=1 SHALL take priority over stall_in and capture: next cycle, PC=redirect_pc, all captured instructions discarded, instr_valid=0.
REQ-023 Redirect in F_WAIT, or in F_REQ with a handshake in the same cycle, SHALL enter F_DROP and discard the next imem_rvalid; otherwise the FSM SHALL enter F_REQ.
REQ-024 Room exists in the unbuffered build only when instr_valid=0 or an instruction is consumed in the same cycle.
REQ-025 imem_rvalid arriving in F_REQ is a protocol violation; it SHALL be ignored.

Reset
REQ-026 While rst=1: PC=RESET_PC, FSM=F_REQ, imem_req=0, instr_valid=0, instr_out=NOP_INSTR, pc_out=RESET_PC, buffer empty.
REQ-027 The first request SHALL be issued in the first cycle after rst deasserts; reset mid-request SHALL abandon the request, and any later imem_rvalid is ignored per REQ-025.

Configuration
REQ-028 Macro FETCH_BUF_EN SHALL compile in a 2-entry instruction FIFO between memory and the output; without it, a single output register is used.
REQ-029 With FETCH_BUF_EN, room SHALL exist when entries + outstanding < 2; the head entry drives the outputs; redirect SHALL empty the FIFO.

Structure
REQ-030 Package pipe_pkg SHALL hold NOP_INSTR, the fetch state enum, and the default RESET_PC.
REQ-031 The FIFO SHALL be sub-module fetch_buf (2 entries, 64-bit {pc,instr}, count 0..2), instantiated only under FETCH_BUF_EN.

Verification
REQ-032 Reset release, imem_ready=1, 1-cycle response 32'h00500093 -> imem_addr=0, then instr_out=32'h00500093, pc_out=0, instr_valid=1.
REQ-033 Three sequential fetches without stall -> pc_out sequence 0, 4, 8; imem_addr never repeats.
REQ-034 stall_in=1 for 3 cycles with instr at PC 4 -> outputs held at PC 4; unbuffered build issues no request; buffered build fetches PC 8 only.
REQ-035 redirect_en=1, redirect_pc=32'h100 while in F_WAIT -> stale response dropped; next valid pc_out=32'h100; instr_valid=0 meanwhile.
REQ-036 redirect_en and stall_in both 1 -> flush wins; instr_out=NOP_INSTR next cycle.
REQ-037 rst pulsed mid-F_WAIT -> outputs at reset values; first new request at RESET_PC.
